// File: rtl/pc_unit.sv
// OTTER program counter: next-PC source select, misaligned target reject,
// and a circular trace of previously committed PC values.
module pc_unit #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC   = '0,
    parameter int                 INC         = 4,
    parameter int                 ALIGN_BITS  = 2,
    parameter int                 TRACE_DEPTH = 8,
    localparam int                IDX_W       = $clog2(TRACE_DEPTH),
    localparam int                CNT_W       = IDX_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PC_WRITE,
    input  logic [2:0]       PC_SEL,
    input  logic [WIDTH-1:0] JALR,
    input  logic [WIDTH-1:0] BRANCH,
    input  logic [WIDTH-1:0] JAL,
    input  logic [WIDTH-1:0] MTVEC,
    input  logic [WIDTH-1:0] MEPC,
    input  logic             INTR_TAKEN,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_NEXT_SEQ,
    output logic             MISALIGN,
    output logic [WIDTH-1:0] BAD_ADDR,
    input  logic [IDX_W-1:0] TRACE_IDX,
    output logic [WIDTH-1:0] TRACE_DATA,
    output logic [CNT_W-1:0] TRACE_COUNT
);

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_JALR   = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_JAL    = 3'd3;
    localparam logic [2:0] SEL_MTVEC  = 3'd4;
    localparam logic [2:0] SEL_MEPC   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TRACE_DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] bad_q;
    logic             mis_q;
    logic [IDX_W-1:0] wptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] trace_mem [TRACE_DEPTH];

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] target;
    logic             target_bad;
    logic             commit;
    logic             reject;
    logic [IDX_W-1:0] rd_ptr;

    // Sequential fetch wraps modulo 2^WIDTH
    assign seq = pc_q + WIDTH'(INC);

    always_comb begin
        target = seq;
        if (INTR_TAKEN) begin
            target = MTVEC;
        end else begin
            unique case (PC_SEL)
                SEL_SEQ:    target = seq;
                SEL_JALR:   target = JALR;
                SEL_BRANCH: target = BRANCH;
                SEL_JAL:    target = JAL;
                SEL_MTVEC:  target = MTVEC;
                SEL_MEPC:   target = MEPC;
                default:    target = seq;
            endcase
        end
    end

    generate
        if (ALIGN_BITS == 0) begin : g_no_align
            assign target_bad = 1'b0;
        end else begin : g_align
            assign target_bad = |target[ALIGN_BITS-1:0];
        end
    endgenerate

    assign commit = PC_WRITE & ~target_bad;
    assign reject = PC_WRITE & target_bad;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q   <= RESET_VEC;
            bad_q  <= '0;
            mis_q  <= 1'b0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mis_q <= reject;
            if (reject) begin
                bad_q <= target;
            end
            if (commit) begin
                pc_q   <= target;
                wptr_q <= wptr_q + IDX_W'(1);
                if (cnt_q != CNT_FULL) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Storage has no reset; validity is tracked by cnt_q alone
    always_ff @(posedge CLK) begin
        if (!RESET && commit) begin
            trace_mem[wptr_q] <= pc_q;
        end
    end

    // Index 0 is the newest entry; power-of-two depth makes the wrap free
    assign rd_ptr = wptr_q - IDX_W'(1) - TRACE_IDX;

    assign PC          = pc_q;
    assign PC_NEXT_SEQ = seq;
    assign MISALIGN    = mis_q;
    assign BAD_ADDR    = bad_q;
    assign TRACE_DATA  = trace_mem[rd_ptr];
    assign TRACE_COUNT = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pc_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          PC_WRITE;
    logic [2:0]    PC_SEL;
    logic [W-1:0]  JALR, BRANCH, JAL, MTVEC, MEPC;
    logic          INTR_TAKEN;
    logic [W-1:0]  PC, PC_NEXT_SEQ, BAD_ADDR, TRACE_DATA;
    logic          MISALIGN;
    logic [2:0]    TRACE_IDX;
    logic [3:0]    TRACE_COUNT;

    pc_unit dut (
        .CLK(CLK), .RESET(RESET), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC),
        .MEPC(MEPC), .INTR_TAKEN(INTR_TAKEN), .PC(PC),
        .PC_NEXT_SEQ(PC_NEXT_SEQ), .MISALIGN(MISALIGN),
        .BAD_ADDR(BAD_ADDR), .TRACE_IDX(TRACE_IDX),
        .TRACE_DATA(TRACE_DATA), .TRACE_COUNT(TRACE_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef enum int {F_PC, F_SEQ, F_MIS, F_BAD, F_CNT, F_TD} fld_t;

    typedef struct {
        int          cyc;
        fld_t        fld;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            case (e.fld)
                F_PC:    got = PC;
                F_SEQ:   got = PC_NEXT_SEQ;
                F_MIS:   got = 32'(MISALIGN);
                F_BAD:   got = BAD_ADDR;
                F_CNT:   got = 32'(TRACE_COUNT);
                default: got = TRACE_DATA;
            endcase
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: checked in cycle %0d, queued for %0d",
                         e.name, cyc, e.cyc);
            end else if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h",
                         e.name, got, e.exp);
            end
        end
    end

    task automatic expect_v(input fld_t f, input logic [31:0] v,
                            input string n);
        exp_t e;
        e.cyc  = cyc;
        e.fld  = f;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_trace(input logic [2:0] idx, input logic [31:0] v,
                            input string n);
        PC_WRITE  = 1'b0;
        TRACE_IDX = idx;
        expect_v(F_TD, v, n);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; PC_WRITE = 1'b0; PC_SEL = 3'd0;
        JALR = '0; BRANCH = '0; JAL = '0; MTVEC = '0; MEPC = '0;
        INTR_TAKEN = 1'b0; TRACE_IDX = '0;
        tick(); tick();
        RESET = 1'b0;
        expect_v(F_PC,  32'h0, "reset_pc");
        expect_v(F_CNT, 32'd0, "reset_cnt");
        expect_v(F_MIS, 32'd0, "reset_mis");
        expect_v(F_BAD, 32'h0, "reset_bad");
        expect_v(F_SEQ, 32'h4, "reset_seq");

        // three sequential commits
        PC_WRITE = 1'b1; PC_SEL = 3'd0;
        tick(); tick(); tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'hC, "seq3_pc");
        expect_v(F_CNT, 32'd3, "seq3_cnt");
        rd_trace(3'd0, 32'h8, "seq3_tr0");
        rd_trace(3'd2, 32'h0, "seq3_tr2");

        PC_WRITE = 1'b1; PC_SEL = 3'd0;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC, 32'h10, "seq4_pc");

        // jal then branch
        PC_WRITE = 1'b1; PC_SEL = 3'd3; JAL = 32'h100;
        tick();
        expect_v(F_PC, 32'h100, "jal_pc");
        PC_SEL = 3'd2; BRANCH = 32'h80;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h80, "br_pc");
        expect_v(F_CNT, 32'd6, "br_cnt");
        rd_trace(3'd0, 32'h100, "br_tr0");
        rd_trace(3'd1, 32'h10,  "br_tr1");

        // misaligned jalr
        PC_WRITE = 1'b1; PC_SEL = 3'd1; JALR = 32'h202;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h80,  "mis_pc_hold");
        expect_v(F_MIS, 32'd1,   "mis_pulse");
        expect_v(F_BAD, 32'h202, "mis_bad");
        expect_v(F_CNT, 32'd6,   "mis_cnt");
        tick();
        expect_v(F_MIS, 32'd0,   "mis_drop");
        expect_v(F_BAD, 32'h202, "mis_bad_hold");

        // back-to-back rejects
        PC_WRITE = 1'b1; JALR = 32'h203;
        tick();
        expect_v(F_MIS, 32'd1,   "b2b_mis1");
        expect_v(F_BAD, 32'h203, "b2b_bad1");
        JALR = 32'h206;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_MIS, 32'd1,   "b2b_mis2");
        expect_v(F_BAD, 32'h206, "b2b_bad2");
        tick();
        expect_v(F_MIS, 32'd0,   "b2b_drop");

        // interrupt overrides PC_SEL, then mret
        PC_WRITE = 1'b1; INTR_TAKEN = 1'b1; PC_SEL = 3'd3;
        MTVEC = 32'h400; JAL = 32'h100;
        tick();
        expect_v(F_PC, 32'h400, "intr_pc");
        INTR_TAKEN = 1'b0; PC_SEL = 3'd5; MEPC = 32'h84;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h84, "mepc_pc");
        expect_v(F_CNT, 32'd8,  "mepc_cnt");
        rd_trace(3'd0, 32'h400, "mepc_tr0");
        rd_trace(3'd1, 32'h80,  "mepc_tr1");

        // misaligned trap vector rejected
        PC_WRITE = 1'b1; INTR_TAKEN = 1'b1; MTVEC = 32'h401;
        tick();
        PC_WRITE = 1'b0; INTR_TAKEN = 1'b0;
        expect_v(F_PC,  32'h84,  "mtvec_mis_pc");
        expect_v(F_MIS, 32'd1,   "mtvec_mis");
        expect_v(F_BAD, 32'h401, "mtvec_bad");

        // reserved select is sequential; count saturates
        PC_WRITE = 1'b1; PC_SEL = 3'd6;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h88, "sel6_pc");
        expect_v(F_CNT, 32'd8,  "sel6_cnt_sat");

        // interrupt without write does nothing
        INTR_TAKEN = 1'b1; MTVEC = 32'h400;
        tick();
        INTR_TAKEN = 1'b0;
        expect_v(F_PC, 32'h88, "intr_nowr_pc");

        // reset wins over a rejecting write
        RESET = 1'b1; PC_WRITE = 1'b1; PC_SEL = 3'd1; JALR = 32'h202;
        tick();
        RESET = 1'b0; PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h0, "rst_mid_pc");
        expect_v(F_MIS, 32'd0, "rst_mid_mis");
        expect_v(F_CNT, 32'd0, "rst_mid_cnt");
        expect_v(F_BAD, 32'h0, "rst_mid_bad");

        // ten sequential commits wrap the trace
        PC_WRITE = 1'b1; PC_SEL = 3'd0;
        for (int i = 0; i < 10; i++) tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h28, "wrap_pc");
        expect_v(F_CNT, 32'd8,  "wrap_cnt");
        rd_trace(3'd0, 32'h24, "wrap_tr0");
        rd_trace(3'd3, 32'h18, "wrap_tr3");
        rd_trace(3'd7, 32'h8,  "wrap_tr7");

        // PC wraps past the top of the address space
        PC_WRITE = 1'b1; PC_SEL = 3'd3; JAL = 32'hFFFF_FFFC;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC,  32'hFFFF_FFFC, "top_pc");
        expect_v(F_SEQ, 32'h0,         "top_seq");
        PC_WRITE = 1'b1; PC_SEL = 3'd0;
        tick();
        PC_WRITE = 1'b0;
        expect_v(F_PC, 32'h0, "top_wrap_pc");

        // reset with a pending jal commit
        tick();
        RESET = 1'b1; PC_WRITE = 1'b1; PC_SEL = 3'd3; JAL = 32'h100;
        tick();
        RESET = 1'b0; PC_WRITE = 1'b0;
        expect_v(F_PC,  32'h0, "rst_jal_pc");
        expect_v(F_CNT, 32'd0, "rst_jal_cnt");
        expect_v(F_MIS, 32'd0, "rst_jal_mis");

        tick();
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
